// File: rtl/taxi_pcie_irq_pkg.sv
// Shared types for the PCIe interrupt coalescing scheduler.
package taxi_pcie_irq_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HOLDOFF = 1'b1
  } irq_coal_state_t;

endpackage

// File: rtl/taxi_pcie_irq_coalesce_vec.sv
// One interrupt vector: moderation FSM, holdoff timer, event counter and config registers.
module taxi_pcie_irq_coalesce_vec
  import taxi_pcie_irq_pkg::*;
#(
  parameter int TIMER_W         = 16,
  parameter int CNT_W           = 8,
  parameter int DEFAULT_HOLDOFF = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               evt,
  input  logic               cfg_wr,
  input  logic               cfg_wr_enable,
  input  logic [TIMER_W-1:0] cfg_wr_holdoff,
  input  logic [CNT_W-1:0]   cfg_wr_thresh,
  output logic               irq,
  output logic               pending
);

  irq_coal_state_t    state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pending_q, pending_d;
  logic               irq_q, irq_d;
  logic               enable_q;
  logic [TIMER_W-1:0] holdoff_q;
  logic [CNT_W-1:0]   thresh_q;
  logic               gate;
  logic               fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // The gate keeps irq low for at least one cycle between pulses so the shim sees an edge.
  assign gate = ~irq_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = (tick && timer_q != '0) ? timer_q - TIMER_W'(1) : timer_q;
    count_d   = count_q;
    pending_d = pending_q;
    fire      = 1'b0;

    case (state_q)
      IDLE: begin
        if (evt) begin
          if (gate) begin
            fire = 1'b1;
          end else begin
            pending_d = 1'b1;
            count_d   = CNT_W'(1);
            state_d   = HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        if (pending_q && gate &&
            (timer_q == '0 || (thresh_q != '0 && count_q >= thresh_q))) begin
          fire = 1'b1;
        end else if (evt) begin
          pending_d = 1'b1;
          count_d   = sat_inc(count_q);
        end else if (timer_q == '0 && !pending_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An event coinciding with a holdoff fire opens the next batch.
    if (fire) begin
      state_d   = HOLDOFF;
      timer_d   = holdoff_q;
      pending_d = evt && (state_q == HOLDOFF);
      count_d   = (evt && (state_q == HOLDOFF)) ? CNT_W'(1) : '0;
    end

    if (!enable_q || (cfg_wr && !cfg_wr_enable)) begin
      state_d   = IDLE;
      timer_d   = '0;
      count_d   = '0;
      pending_d = 1'b0;
    end

    irq_d = fire && enable_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
      enable_q  <= 1'b1;
      holdoff_q <= TIMER_W'(DEFAULT_HOLDOFF);
      thresh_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      if (cfg_wr) begin
        enable_q  <= cfg_wr_enable;
        holdoff_q <= cfg_wr_holdoff;
        thresh_q  <= cfg_wr_thresh;
      end
    end
  end

  assign irq     = irq_q;
  assign pending = pending_q;

endmodule

// File: rtl/taxi_pcie_irq_coalesce.sv
// Per-vector MSI interrupt moderation: shared tick prescaler, config decode and IRQ_CNT vector engines.
module taxi_pcie_irq_coalesce
  import taxi_pcie_irq_pkg::*;
#(
  parameter int IRQ_CNT         = 32,
  parameter int TIMER_W         = 16,
  parameter int CNT_W           = 8,
  parameter int PRESCALE        = 250,
  parameter int DEFAULT_HOLDOFF = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IRQ_CNT-1:0]         evt,
  input  logic                       cfg_wr_en,
  input  logic [$clog2(IRQ_CNT)-1:0] cfg_wr_index,
  input  logic                       cfg_wr_enable,
  input  logic [TIMER_W-1:0]         cfg_wr_holdoff,
  input  logic [CNT_W-1:0]           cfg_wr_thresh,
  output logic [IRQ_CNT-1:0]         irq_out,
  output logic [IRQ_CNT-1:0]         irq_pending
);

  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = $clog2(IRQ_CNT);

  logic [PS_W-1:0] ps_cnt_q;
  logic            tick;

  // With PRESCALE=1 the counter sits at 0 and tick is permanently asserted.
  assign tick = (ps_cnt_q == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      ps_cnt_q <= '0;
    end else begin
      ps_cnt_q <= ps_cnt_q + PS_W'(1);
    end
  end

  for (genvar i = 0; i < IRQ_CNT; i++) begin : g_vec
    taxi_pcie_irq_coalesce_vec #(
      .TIMER_W         (TIMER_W),
      .CNT_W           (CNT_W),
      .DEFAULT_HOLDOFF (DEFAULT_HOLDOFF)
    ) u_vec (
      .clk            (clk),
      .rst            (rst),
      .tick           (tick),
      .evt            (evt[i]),
      .cfg_wr         (cfg_wr_en && (cfg_wr_index == IDX_W'(i))),
      .cfg_wr_enable  (cfg_wr_enable),
      .cfg_wr_holdoff (cfg_wr_holdoff),
      .cfg_wr_thresh  (cfg_wr_thresh),
      .irq            (irq_out[i]),
      .pending        (irq_pending[i])
    );
  end

endmodule
